// File: rtl/fwd_select_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
//
// Handshake: the id_* fields are meaningful only while id_valid is high.
// The unit accepts the ID instruction into EX on a rising edge exactly when
// id_valid & !stall & !flush. stall is the unit's back-pressure and is
// combinational, so the ID stage must hold its fields stable while stall is
// high and re-present the same instruction in the next cycle.
interface fwd_select_unit_if #(
    parameter int NUM_STALL_BITS = 16
);
    logic                      id_valid;
    logic [4:0]                id_rs;
    logic [4:0]                id_rt;
    logic                      id_use_rs;
    logic                      id_use_rt;
    logic [4:0]                id_dest;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      flush;
    logic [1:0]                forward_a;
    logic [1:0]                forward_b;
    logic                      stall;
    logic [NUM_STALL_BITS-1:0] stall_count;

    // Pipeline control side: drives the ID fields, consumes the selects.
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_dest, id_reg_write, id_mem_read, flush,
        input  forward_a, forward_b, stall, stall_count
    );

    // Forwarding unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_dest, id_reg_write, id_mem_read, flush,
        output forward_a, forward_b, stall, stall_count
    );
endinterface

// File: rtl/fwd_select_unit.sv
// Forwarding-select and load-use hazard unit.
// Keeps a shadow copy of the EX and MEM destination/write flags, registers
// the 2-bit operand mux selects for the instruction entering EX, and raises
// a combinational stall when the ID instruction needs a load still in EX.
// Select codes: 00 = ID/EX value, 01 = EX/MEM ALU result, 10 = MEM/WB value.
module fwd_select_unit #(
    parameter int NUM_STALL_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fwd_select_unit_if.slave     bus
);

    // Shadow EX stage
    logic [4:0] ex_dest_q,  ex_dest_d;
    logic       ex_rw_q,    ex_rw_d;
    logic       ex_mr_q,    ex_mr_d;
    // Shadow MEM stage
    logic [4:0] mem_dest_q, mem_dest_d;
    logic       mem_rw_q,   mem_rw_d;
    // Registered selects and stall counter
    logic [1:0] fwd_a_q,    fwd_a_d;
    logic [1:0] fwd_b_q,    fwd_b_d;
    logic [NUM_STALL_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic stall_c;
    logic issue_c;

    // The EX producer is checked first so the newest value wins; $0 and
    // unused sources never forward.
    function automatic logic [1:0] fwd_sel(
        input logic       use_src,
        input logic [4:0] src,
        input logic       ex_rw,
        input logic [4:0] ex_dest,
        input logic       mem_rw,
        input logic [4:0] mem_dest
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != 5'd0)) begin
            if (ex_rw && (ex_dest == src)) begin
                sel = 2'b01;
            end else if (mem_rw && (mem_dest == src)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    // Load-use detection, next shadow-stage contents, selects and counter.
    always_comb begin
        stall_c = bus.id_valid && !bus.flush && ex_mr_q && ex_rw_q &&
                  (ex_dest_q != 5'd0) &&
                  ((bus.id_use_rs && (bus.id_rs == ex_dest_q)) ||
                   (bus.id_use_rt && (bus.id_rt == ex_dest_q)));
        issue_c = bus.id_valid && !stall_c && !bus.flush;

        // MEM always follows EX.
        mem_dest_d = ex_dest_q;
        mem_rw_d   = ex_rw_q;

        // Default: a bubble enters EX with neutral selects.
        ex_dest_d = 5'd0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
        fwd_a_d   = 2'b00;
        fwd_b_d   = 2'b00;
        if (issue_c) begin
            ex_dest_d = bus.id_dest;
            ex_rw_d   = bus.id_reg_write;
            ex_mr_d   = bus.id_mem_read;
            fwd_a_d   = fwd_sel(bus.id_use_rs, bus.id_rs, ex_rw_q, ex_dest_q,
                                mem_rw_q, mem_dest_q);
            fwd_b_d   = fwd_sel(bus.id_use_rt, bus.id_rt, ex_rw_q, ex_dest_q,
                                mem_rw_q, mem_dest_q);
        end

        // Saturating count of stall cycles.
        stall_cnt_d = stall_cnt_q;
        if (stall_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset leaves bubbles in both shadow stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_dest_q   <= 5'd0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_dest_q  <= 5'd0;
            mem_rw_q    <= 1'b0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            ex_dest_q   <= ex_dest_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_dest_q  <= mem_dest_d;
            mem_rw_q    <= mem_rw_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.forward_a   = fwd_a_q;
    assign bus.forward_b   = fwd_b_q;
    assign bus.stall       = stall_c;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: doc/fwd_select_unit.md
# fwd_select_unit

Pipeline forwarding and load-use hazard unit that produces the 2-bit select codes consumed by the 3-input operand muxes in front of the ALU. It tracks the destination register, register-write and memory-read flags of the instructions in the EX and MEM stages in its own shadow pipeline. Each cycle it registers the forwarding selects for the instruction entering EX, and it raises a combinational stall on a load-use dependency. It sits between the ID/EX pipeline register and the ALU operand muxes.

## Interface
- NUM_STALL_BITS, 16, width of saturating stall counter
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  source register A of ID instruction
- id_rt  in  5  source register B of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dest  in  5  destination register of ID instruction
- id_reg_write  in  1  ID instruction writes register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch taken; instruction in ID is discarded
- forward_a  out  2  select for ALU operand A mux (registered)
- forward_b  out  2  select for ALU operand B mux (registered)
- stall  out  1  hold PC and IF/ID, insert bubble (combinational)
- stall_count  out  NUM_STALL_BITS  total stall cycles, saturating

## Operation
- Select encoding, matching mux input order: 2'b00 = ID/EX register value, 2'b01 = EX/MEM ALU result, 2'b10 = MEM/WB writeback value; 2'b11 never driven.
- Shadow stages: EX {dest, reg_write, mem_read}, MEM {dest, reg_write}. A bubble sets all flags to 0 and dest to 0.
- stall = id_valid & !flush & EX.mem_read & EX.reg_write & (EX.dest != 0) & ((id_use_rs & id_rs == EX.dest) | (id_use_rt & id_rt == EX.dest)).
- Forward select computation for operand A, applied to id_rs and id_use_rs; operand B is the same using id_rt and id_use_rt:
  - If the source is not used, or the register is $0, the select is 00.
  - Else, if EX.reg_write and EX.dest matches, the select is 01. This match takes priority, so the newest producer wins.
  - Else, if MEM.reg_write and MEM.dest matches, the select is 10.
  - Else the select is 00.
- Update on each rising edge:
  - MEM is loaded from EX, unconditionally.
  - If id_valid & !stall & !flush, EX is loaded from the ID fields and forward_a/forward_b are loaded with the computed selects.
  - Otherwise, EX is loaded with a bubble and forward_a/forward_b are loaded with 00.
- stall_count increments on every cycle where stall=1. It holds at all-ones and does not wrap.
- flush has priority over stall. When flush=1, stall is 0 and a bubble enters EX.

## Timing
- Reset (asynchronous, immediate): forward_a=00, forward_b=00, stall_count=0, both shadow stages hold bubbles, so stall=0.
- forward_a/forward_b change only on clock edges. They are valid during the cycle in which the instruction occupies EX, i.e. one cycle after it was presented in ID.
- stall has zero-cycle latency from the ID inputs and the EX state.
- A load-use dependency produces exactly one stall cycle. The held instruction is re-presented in the next cycle; the load is then in MEM, so that instruction receives select 10.
- Back-to-back dependencies, e.g. add r3 followed by sub using r3, give 01 with no stall.
- A reset asserted mid-stall clears stall in the same cycle, with no edge needed.
- Writes landing in the WB stage are covered by register-file write-before-read and are not forwarded.

## Test plan
- Reset: assert reset with stale state present → forward_a=00, forward_b=00, stall=0, stall_count=0 immediately, before any clock edge.
- EX forward: add r3 (dest=3, reg_write=1), then sub rs=3, rt=4 → in the EX cycle of sub, forward_a=01 and forward_b=00. The same sequence with the producer's dest=0 → forward_a=00.
- MEM forward and priority:
  - add r5, nop, or rs=5 → forward_a=10.
  - add r5, add r5, or rs=5 → forward_a=01 (newer producer wins).
- Load-use: lw r7 (mem_read=1), then add rt=7 → stall=1 for exactly one cycle, and stall_count goes to 1. The re-presented add then gets forward_b=10, and forward_b=00 during the bubble cycle.
- Flush: lw r7, then flush=1 with a dependent instruction in ID → stall=0, a bubble enters EX, and a following instruction reading r7 gets 01 from no-one, i.e. 00 when only the bubble is in EX and 10 once the load is in MEM.
- Saturation: with NUM_STALL_BITS=2, force 5 load-use stalls → stall_count reads 1, 2, 3, 3, 3.
